seq_detector_mealy_param: RTL and testbench
===========================================

// Module: seq_detector_mealy_param
// PURPOSE
//  Parametrised Mealy serial-pattern detector; next generation of the fixed 2-bit-state X/Z detector.
//  Matches a runtime-programmable pattern of 1..PATTERN_W bits on a gated serial bit stream.
//  Supports overlapping and non-overlapping modes, and counts matches.
//  Sits behind a serial front-end; z drives event logic, match_cnt goes to status registers.
// PARAMETERS
//  PATTERN_W        8           max pattern length in bits (>=2)
//  PATTERN_DEFAULT  8'b00001011 pattern loaded at reset (low PATTERN_W bits)
//  LEN_DEFAULT      4           pattern length loaded at reset (1..PATTERN_W)
//  OVERLAP_DEFAULT  1'b1        mode at reset: 1 = overlapping, 0 = non-overlapping
//  CNT_W            16          match counter width
// PORTS
//  clk          in   1                    single clock, rising edge
//  reset        in   1                    synchronous, active-high
//  in_valid     in   1                    x is a valid stream bit this cycle
//  x            in   1                    serial input bit
//  cfg_load     in   1                    one-cycle strobe: latch the cfg_* inputs
//  cfg_pattern  in   PATTERN_W            pattern; bit [cfg_len-1] is received first, bit [0] last
//  cfg_len      in   $clog2(PATTERN_W+1)  pattern length, legal 1..PATTERN_W
//  cfg_overlap  in   1                    mode, as OVERLAP_DEFAULT
//  z            out  1                    Mealy match pulse (combinational from state, x, in_valid)
//  match_cnt    out  CNT_W                saturating count of z pulses
//  state_o      out  $clog2(PATTERN_W)    current matched-prefix length (debug)
// BEHAVIOUR
//  - Reset (sync, wins over everything): state=0, history=0, match_cnt=0;
//    pattern/len/overlap regs = *_DEFAULT; z forced 0 while reset is high.
//  - state = number of pattern prefix bits currently matched, range 0..len-1.
//  - history = last PATTERN_W-1 accepted bits; updated only on accepted bits.
//  - Accepted bit: in_valid=1 and cfg_load=0. No accepted bit -> state, history, count hold; z=0.
//  - z = accepted & (state==len-1) & (x == pattern[0]). Same-cycle Mealy output, no register.
//  - Next state on accept: s' = largest k < len such that the last k accepted bits (incl. x)
//    equal pattern bits [len-1 : len-k]. Exception: non-overlap mode with z=1 -> s' = 0.
//  - len==1: state stays 0; z = accepted & (x==pattern[0]) on every matching bit.
//  - match_cnt increments on z; saturates at all-ones, never wraps.
//  - cfg_load=1: latch cfg_pattern/cfg_len/cfg_overlap, clear state and history (count kept).
//    Any in_valid bit in the same cycle is dropped (z=0). New config applies from the next cycle.
//  - cfg_len of 0 or >PATTERN_W is illegal: clamp to PATTERN_W; the bench asserts it is never driven.
//  - Pattern bits above len-1 are ignored.
// STRUCTURE
//  - seq_det_pkg: state/len/count width functions (clog2-based) and mode encoding constants
//    (MODE_OVERLAP=1, MODE_NONOVERLAP=0).
//  - Sub-module seq_det_next_state: combinational; inputs {history,x}, pattern, len, state, mode;
//    outputs s' and hit. Implements a per-k prefix/suffix compare plus a priority select.
//  - Top: config regs, state reg, history shift reg, saturating counter, z gating.
// TESTING
//  1. Defaults (1011, len4, overlap), x=1,0,1,1,0,1,1 every cycle -> z=1 on bits 4 and 7; match_cnt=2.
//  2. Same stream, cfg_load overlap=0 first -> z=1 only on bit 4; match_cnt=1; state_o=0 after bit 4.
//  3. Stream 1,0,1 with in_valid low 3 cycles, then 1 -> state_o holds 3 across the gap; z=1 on final bit.
//  4. After 1,0,1 (state_o=3), assert reset one cycle, send 1 -> z=0, state_o=1, match_cnt=0.
//  5. cfg_load pattern=1 len=1, CNT_W=2 build, send five 1s -> z every bit; match_cnt sticks at 3.
//  6. cfg_load with in_valid=1, x completing a match the same cycle -> z=0, state_o=0, count unchanged.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared widths and mode encoding for the parametrised Mealy pattern detector.
package seq_det_pkg;

   typedef enum logic {
      MODE_NONOVERLAP = 1'b0,
      MODE_OVERLAP    = 1'b1
   } mode_e;

   // A state value ranges 0..len-1, so PATTERN_W-1 is the largest one needed.
   function automatic int state_w(input int pattern_w);
      return (pattern_w < 2) ? 1 : $clog2(pattern_w);
   endfunction

   function automatic int len_w(input int pattern_w);
      return $clog2(pattern_w + 1);
   endfunction

   function automatic int cnt_w(input int cnt_bits);
      return (cnt_bits < 1) ? 1 : cnt_bits;
   endfunction

endpackage

// File: rtl/seq_det_next_state.sv
// Combinational next-state and match logic: per-length prefix/suffix compare plus priority select.
module seq_det_next_state
   import seq_det_pkg::*;
#(
   parameter int PATTERN_W = 8,
   localparam int LEN_W    = len_w(PATTERN_W),
   localparam int STATE_W  = state_w(PATTERN_W)
) (
   input  logic [PATTERN_W-2:0] history,
   input  logic                 x,
   input  logic [PATTERN_W-1:0] pattern,
   input  logic [LEN_W-1:0]     len,
   input  logic [STATE_W-1:0]   state,
   input  mode_e                mode,
   output logic [STATE_W-1:0]   state_next,
   output logic                 hit
);

   logic [PATTERN_W-1:0] recent;
   logic [PATTERN_W-1:0] cand;
   logic [STATE_W:0]     state_plus1;

   assign recent      = {history, x};
   assign state_plus1 = {1'b0, state} + (STATE_W+1)'(1);
   assign cand[0]     = 1'b0;

   // A prefix can grow by at most one bit per accepted bit; bounding k by state+1 also
   // keeps the zeroed history left behind by a clear from faking a prefix match.
   genvar gi;
   generate
      for (gi = 1; gi < PATTERN_W; gi++) begin : g_cmp
         localparam logic [PATTERN_W-1:0] LOW_MASK = PATTERN_W'((1 << gi) - 1);
         logic [LEN_W-1:0]     shift_amt;
         logic [PATTERN_W-1:0] diff;
         assign shift_amt = len - LEN_W'(gi);
         assign diff      = (((recent & LOW_MASK) << shift_amt) ^ pattern) & (LOW_MASK << shift_amt);
         assign cand[gi]  = (LEN_W'(gi) < len) && ((STATE_W+1)'(gi) <= state_plus1) && (diff == '0);
      end
   endgenerate

   assign hit = (LEN_W'(state) == len - LEN_W'(1)) && (x == pattern[0]);

   always_comb begin
      state_next = '0;
      for (int k = 1; k < PATTERN_W; k++) begin
         if (cand[k]) state_next = STATE_W'(k);
      end
      if (hit && mode == MODE_NONOVERLAP) state_next = '0;
   end

endmodule

// File: rtl/seq_detector_mealy_param.sv
// Runtime-programmable Mealy serial-pattern detector with saturating match counter.
module seq_detector_mealy_param
   import seq_det_pkg::*;
#(
   parameter int                   PATTERN_W       = 8,
   parameter logic [PATTERN_W-1:0] PATTERN_DEFAULT = PATTERN_W'('b00001011),
   parameter int                   LEN_DEFAULT     = 4,
   parameter logic                 OVERLAP_DEFAULT = 1'b1,
   parameter int                   CNT_W           = 16,
   localparam int                  LEN_W           = len_w(PATTERN_W),
   localparam int                  STATE_W         = state_w(PATTERN_W),
   localparam int                  CW              = cnt_w(CNT_W)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic                 x,
   input  logic                 cfg_load,
   input  logic [PATTERN_W-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]     cfg_len,
   input  logic                 cfg_overlap,
   output logic                 z,
   output logic [CW-1:0]        match_cnt,
   output logic [STATE_W-1:0]   state_o
);

   logic [PATTERN_W-1:0] pattern_reg;
   logic [LEN_W-1:0]     len_reg;
   mode_e                mode_reg;
   logic [STATE_W-1:0]   state_reg;
   logic [PATTERN_W-2:0] history_reg;
   logic [CW-1:0]        cnt_reg;

   logic [STATE_W-1:0]   state_next;
   logic [PATTERN_W-1:0] recent;
   logic [LEN_W-1:0]     len_clamped;
   logic                 hit;
   logic                 accepted;

   assign accepted = in_valid & ~cfg_load & ~reset;
   assign recent   = {history_reg, x};
   assign z        = accepted & hit;

   assign match_cnt = cnt_reg;
   assign state_o   = state_reg;

   always_comb begin
      len_clamped = cfg_len;
      if (cfg_len == '0 || cfg_len > LEN_W'(PATTERN_W)) len_clamped = LEN_W'(PATTERN_W);
   end

   seq_det_next_state #(
      .PATTERN_W (PATTERN_W)
   ) u_next_state (
      .history    (history_reg),
      .x          (x),
      .pattern    (pattern_reg),
      .len        (len_reg),
      .state      (state_reg),
      .mode       (mode_reg),
      .state_next (state_next),
      .hit        (hit)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         pattern_reg <= PATTERN_DEFAULT;
         len_reg     <= LEN_W'(LEN_DEFAULT);
         mode_reg    <= mode_e'(OVERLAP_DEFAULT);
         state_reg   <= '0;
         history_reg <= '0;
         cnt_reg     <= '0;
      end else if (cfg_load) begin
         pattern_reg <= cfg_pattern;
         len_reg     <= len_clamped;
         mode_reg    <= mode_e'(cfg_overlap);
         state_reg   <= '0;
         history_reg <= '0;
      end else if (accepted) begin
         state_reg   <= state_next;
         history_reg <= recent[PATTERN_W-2:0];
         if (z && cnt_reg != '1) cnt_reg <= cnt_reg + CW'(1);
      end
   end

endmodule

// File: tb/tb_seq_detector_mealy_param.sv
// Scoreboard bench: a sliding-window reference model predicts z, state_o and both counters.
module tb_seq_detector_mealy_param;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic       x = 1'b0;
   logic       cfg_load = 1'b0;
   logic [7:0] cfg_pattern = 8'h00;
   logic [3:0] cfg_len = 4'd4;
   logic       cfg_overlap = 1'b1;
   logic        z, z2;
   logic [15:0] match_cnt;
   logic [1:0]  match_cnt2;
   logic [2:0]  state_o, state_o2;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_pat;
   int         m_len;
   bit         m_ovl;
   bit         hist_q[$];
   int         m_cnt, m_cnt2;
   bit         exp_z_q[$];

   seq_detector_mealy_param #(.PATTERN_W(8), .CNT_W(16)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .cfg_load(cfg_load),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
      .z(z), .match_cnt(match_cnt), .state_o(state_o)
   );

   seq_detector_mealy_param #(.PATTERN_W(8), .CNT_W(2)) u_dut2 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .cfg_load(cfg_load),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
      .z(z2), .match_cnt(match_cnt2), .state_o(state_o2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (cfg_load && !reset)
         assert (cfg_len >= 4'd1 && cfg_len <= 4'd8) else $error("illegal cfg_len %0d driven", cfg_len);
   end

   // Last k model bits, oldest first, against pattern bits [len-1 -: k].
   function automatic bit window_match(input int k);
      if (k < 1 || hist_q.size() < k) return 1'b0;
      for (int j = 0; j < k; j++)
         if (hist_q[hist_q.size() - k + j] != m_pat[m_len - 1 - j]) return 1'b0;
      return 1'b1;
   endfunction

   // One clock: drive at posedge+1, check z at negedge, check state/counters at next posedge+1.
   task automatic cycle(input bit rst, input bit v, input bit xb, input bit ld,
                        input logic [7:0] p, input int l, input bit o, output bit z_seen);
      bit acc, ez, e;
      int es;
      reset = rst; in_valid = v; x = xb; cfg_load = ld;
      cfg_pattern = p; cfg_len = 4'(l); cfg_overlap = o;
      acc = v && !ld && !rst;
      ez = 1'b0;
      if (acc) begin
         hist_q.push_back(xb);
         ez = window_match(m_len);
      end
      exp_z_q.push_back(ez);
      @(negedge clk);
      e = exp_z_q.pop_front();
      z_seen = z;
      checks += 2;
      if (z !== e) begin
         errors++;
         $display("FAIL z: got %b expected %b", z, e);
      end
      if (z2 !== e) begin
         errors++;
         $display("FAIL z_cnt2: got %b expected %b", z2, e);
      end
      @(posedge clk);
      if (rst) begin
         m_pat = 8'b00001011; m_len = 4; m_ovl = 1'b1;
         hist_q.delete(); m_cnt = 0; m_cnt2 = 0;
      end else if (ld) begin
         m_pat = p; m_len = l; m_ovl = o;
         hist_q.delete();
      end else if (acc && ez) begin
         if (m_cnt < 65535) m_cnt++;
         if (m_cnt2 < 3) m_cnt2++;
         if (!m_ovl) hist_q.delete();
      end
      while (hist_q.size() > 16) void'(hist_q.pop_front());
      es = 0;
      for (int k = 1; k < m_len; k++)
         if (window_match(k)) es = k;
      #1;
      checks += 4;
      if (state_o !== 3'(es)) begin
         errors++;
         $display("FAIL state_o: got %0d expected %0d", state_o, es);
      end
      if (state_o2 !== 3'(es)) begin
         errors++;
         $display("FAIL state_o_cnt2: got %0d expected %0d", state_o2, es);
      end
      if (match_cnt !== 16'(m_cnt)) begin
         errors++;
         $display("FAIL match_cnt: got %0d expected %0d", match_cnt, m_cnt);
      end
      if (match_cnt2 !== 2'(m_cnt2)) begin
         errors++;
         $display("FAIL match_cnt_sat: got %0d expected %0d", match_cnt2, m_cnt2);
      end
      $display("txn rst=%0b v=%0b x=%0b ld=%0b z=%0b state=%0d cnt=%0d cnt2=%0d",
               rst, v, xb, ld, z_seen, state_o, match_cnt, match_cnt2);
   endtask

   task automatic send(input bit v, input bit xb, output bit z_seen);
      cycle(1'b0, v, xb, 1'b0, 8'h00, 4, 1'b1, z_seen);
   endtask

   task automatic do_reset();
      bit zs;
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4, 1'b1, zs);
   endtask

   task automatic load(input logic [7:0] p, input int l, input bit o);
      bit zs;
      cycle(1'b0, 1'b0, 1'b0, 1'b1, p, l, o, zs);
   endtask

   task automatic test_reset();
      bit zs;
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4, 1'b1, zs);
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4, 1'b1, zs);
      checks += 3;
      if (zs !== 1'b0) begin errors++; $display("FAIL reset_z: got %b expected 0", zs); end
      if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
      if (match_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", match_cnt); end
   endtask

   task automatic test_overlap_default();
      bit stream[7] = '{1, 0, 1, 1, 0, 1, 1};
      bit exp_z[7]  = '{0, 0, 0, 1, 0, 0, 1};
      bit zs;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         send(1'b1, stream[i], zs);
         checks++;
         if (zs !== exp_z[i]) begin
            errors++;
            $display("FAIL overlap_z_bit%0d: got %b expected %b", i + 1, zs, exp_z[i]);
         end
      end
      checks++;
      if (match_cnt !== 16'd2) begin errors++; $display("FAIL overlap_cnt: got %0d expected 2", match_cnt); end
   endtask

   task automatic test_nonoverlap();
      bit stream[7] = '{1, 0, 1, 1, 0, 1, 1};
      bit exp_z[7]  = '{0, 0, 0, 1, 0, 0, 0};
      bit zs;
      do_reset();
      load(8'b00001011, 4, 1'b0);
      for (int i = 0; i < 7; i++) begin
         send(1'b1, stream[i], zs);
         checks++;
         if (zs !== exp_z[i]) begin
            errors++;
            $display("FAIL nonoverlap_z_bit%0d: got %b expected %b", i + 1, zs, exp_z[i]);
         end
         if (i == 3) begin
            checks++;
            if (state_o !== 3'd0) begin errors++; $display("FAIL nonoverlap_state: got %0d expected 0", state_o); end
         end
      end
      checks++;
      if (match_cnt !== 16'd1) begin errors++; $display("FAIL nonoverlap_cnt: got %0d expected 1", match_cnt); end
   endtask

   task automatic test_gap();
      bit zs;
      do_reset();
      send(1'b1, 1'b1, zs); send(1'b1, 1'b0, zs); send(1'b1, 1'b1, zs);
      for (int i = 0; i < 3; i++) begin
         send(1'b0, i[0], zs);
         checks++;
         if (state_o !== 3'd3) begin errors++; $display("FAIL gap_hold: got %0d expected 3", state_o); end
      end
      send(1'b1, 1'b1, zs);
      checks++;
      if (zs !== 1'b1) begin errors++; $display("FAIL gap_final_z: got %b expected 1", zs); end
   endtask

   task automatic test_reset_mid();
      bit zs;
      do_reset();
      send(1'b1, 1'b1, zs); send(1'b1, 1'b0, zs); send(1'b1, 1'b1, zs);
      do_reset();
      send(1'b1, 1'b1, zs);
      checks += 3;
      if (zs !== 1'b0) begin errors++; $display("FAIL midreset_z: got %b expected 0", zs); end
      if (state_o !== 3'd1) begin errors++; $display("FAIL midreset_state: got %0d expected 1", state_o); end
      if (match_cnt !== 16'd0) begin errors++; $display("FAIL midreset_cnt: got %0d expected 0", match_cnt); end
   endtask

   task automatic test_len1_saturate();
      bit zs;
      do_reset();
      load(8'b00000001, 1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         send(1'b1, 1'b1, zs);
         checks++;
         if (zs !== 1'b1) begin errors++; $display("FAIL len1_z_bit%0d: got %b expected 1", i + 1, zs); end
      end
      checks += 2;
      if (match_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_cnt: got %0d expected 3", match_cnt2); end
      if (match_cnt !== 16'd5) begin errors++; $display("FAIL len1_cnt: got %0d expected 5", match_cnt); end
   endtask

   task automatic test_cfg_collision();
      bit zs;
      logic [15:0] cnt_before;
      do_reset();
      send(1'b1, 1'b1, zs); send(1'b1, 1'b0, zs); send(1'b1, 1'b1, zs); send(1'b1, 1'b1, zs);
      send(1'b1, 1'b0, zs); send(1'b1, 1'b1, zs);
      cnt_before = match_cnt;
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'b00001011, 4, 1'b1, zs);
      checks += 3;
      if (zs !== 1'b0) begin errors++; $display("FAIL collide_z: got %b expected 0", zs); end
      if (state_o !== 3'd0) begin errors++; $display("FAIL collide_state: got %0d expected 0", state_o); end
      if (match_cnt !== 16'd1 || match_cnt !== cnt_before)
         begin errors++; $display("FAIL collide_cnt: got %0d expected 1", match_cnt); end
   endtask

   task automatic test_random();
      bit zs;
      for (int c = 0; c < 4; c++) begin
         load(8'($urandom), int'($urandom_range(2, 5)), 1'($urandom));
         for (int i = 0; i < 60; i++)
            send(($urandom_range(0, 3) != 0), 1'($urandom), zs);
      end
   endtask

   initial begin
      m_pat = 8'b00001011; m_len = 4; m_ovl = 1'b1; m_cnt = 0; m_cnt2 = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_overlap_default();
      test_nonoverlap();
      test_gap();
      test_reset_mid();
      test_len1_saturate();
      test_cfg_collision();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
